// File: rtl/divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
package divider_pkg;

    localparam int DW    = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    localparam logic [DW-1:0] DIVZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/adder_RCA_33b.sv
// 33-bit ripple-carry adder, one full-adder cell per bit.
module adder_RCA_33b (
    input  logic [32:0] A_i,
    input  logic [32:0] B_i,
    input  logic        C_i,
    output logic [32:0] S_o,
    output logic        C_o
);

    logic carry;

    always_comb begin
        carry = C_i;
        S_o   = '0;
        for (int i = 0; i < 33; i++) begin
            S_o[i] = A_i[i] ^ B_i[i] ^ carry;
            carry  = (A_i[i] & B_i[i]) | (carry & (A_i[i] ^ B_i[i]));
        end
        C_o = carry;
    end

endmodule

// File: rtl/subtractor_33b.sv
// 33-bit subtractor: a - b as a + ~b + 1; borrow is the inverted carry-out.
module subtractor_33b (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] diff,
    output logic        borrow
);

    logic carry_out;

    adder_RCA_33b u_adder (
        .A_i (a),
        .B_i (~b),
        .C_i (1'b1),
        .S_o (diff),
        .C_o (carry_out)
    );

    assign borrow = ~carry_out;

endmodule

// File: rtl/divider_seq.sv
// Sequential 32b/32b restoring divider, signed or unsigned, one quotient bit per clock.
// start/busy/valid handshake: EN_i is accepted only while BUSY_o=0; VALID_o marks held results.
module divider_seq
    import divider_pkg::*;
(
    input  logic          CLK_i,
    input  logic          RSTN_i,
    input  logic          EN_i,
    input  logic          SIGNED_i,
    input  logic [DW-1:0] DIN1_i,
    input  logic [DW-1:0] DIN2_i,
    output logic          BUSY_o,
    output logic          VALID_o,
    output logic [DW-1:0] QUOT_o,
    output logic [DW-1:0] REM_o,
    output logic          DIVZ_o,
    output div_state_t    STATE_o
);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             divz;
    logic [DW-1:0]    dvd;
    logic [DW-1:0]    dsr_mag;
    logic [DW-1:0]    quot;
    logic [DW:0]      rem;
    logic [DW:0]      shifted;
    logic [DW:0]      trial;
    logic             borrow;
    logic             rem_msb_unused;

    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + DW'(1)) : v;
    endfunction

    // The remainder stays below the divisor, so its top bit never feeds the next shift.
    assign shifted        = {rem[DW-1:0], quot[DW-1]};
    assign rem_msb_unused = rem[DW];

    subtractor_33b u_sub (
        .a      (shifted),
        .b      ({1'b0, dsr_mag}),
        .diff   (trial),
        .borrow (borrow)
    );

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (EN_i) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(DW - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY_o  = (state != IDLE);
    assign STATE_o = state;

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            cnt     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            divz    <= 1'b0;
            dvd     <= '0;
            dsr_mag <= '0;
            quot    <= '0;
            rem     <= '0;
            VALID_o <= 1'b0;
            QUOT_o  <= '0;
            REM_o   <= '0;
            DIVZ_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN_i) begin
                        sign_q  <= SIGNED_i & (DIN1_i[DW-1] ^ DIN2_i[DW-1]);
                        sign_r  <= SIGNED_i & DIN1_i[DW-1];
                        divz    <= (DIN2_i == '0);
                        dvd     <= DIN1_i;
                        quot    <= cond_neg(DIN1_i, SIGNED_i & DIN1_i[DW-1]);
                        dsr_mag <= cond_neg(DIN2_i, SIGNED_i & DIN2_i[DW-1]);
                        rem     <= '0;
                        cnt     <= '0;
                        VALID_o <= 1'b0;
                    end
                end
                CALC: begin
                    rem  <= borrow ? shifted : trial;
                    quot <= {quot[DW-2:0], ~borrow};
                    cnt  <= cnt + CNT_W'(1);
                end
                FIX: begin
                    QUOT_o  <= divz ? DIVZ_QUOT : cond_neg(quot, sign_q);
                    REM_o   <= divz ? dvd : cond_neg(rem[DW-1:0], sign_r);
                    DIVZ_o  <= divz;
                    VALID_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential 32b / 32b integer divider, signed or unsigned, restoring algorithm, one quotient bit per clock. It is the inverse companion to the sequential multiplier and uses the same start/busy/valid handshake, so both can sit side by side behind one arithmetic-unit controller. It resolves one operation per 33 cycles and keeps results stable until the next operation is accepted.

## Interface
- Parameters: none; data width is fixed at 32 via the package constant `DW`.
- `CLK_i` in 1: clock; all state changes on the rising edge.
- `RSTN_i` in 1: reset, asynchronous, active-low.
- `EN_i` in 1: start request; sampled only when `BUSY_o`=0.
- `SIGNED_i` in 1: 1 = two's-complement operands, 0 = unsigned; sampled with `EN_i`.
- `DIN1_i` in 32: dividend; sampled with `EN_i`.
- `DIN2_i` in 32: divisor; sampled with `EN_i`.
- `BUSY_o` out 1: operation in progress.
- `VALID_o` out 1: result registers hold a completed result.
- `QUOT_o` out 32: quotient.
- `REM_o` out 32: remainder.
- `DIVZ_o` out 1: last completed operation had divisor = 0.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC when `EN_i`=1.
  - CALC → FIX when the iteration counter reaches 31.
  - FIX → IDLE unconditionally.
- Accept (IDLE with `EN_i`=1):
  - Latch `SIGNED_i`, `sign_q` = signed & (d1[31] ^ d2[31]), `sign_r` = signed & d1[31], and `divz` = (d2 == 0).
  - Load magnitudes |d1| and |d2| (negated only when signed and MSB=1); 0x80000000 becomes unsigned 2^31.
  - Clear the 33b partial remainder and the 6b counter.
  - Clear `VALID_o`.
- CALC, each cycle:
  - Shift {rem, quot} left by one.
  - Compute trial = rem[32:0] − {1'b0, |d2|} on the 33b subtractor.
  - If trial ≥ 0 (borrow clear): rem ← trial and quot bit0 ← 1. Otherwise quot bit0 ← 0.
  - Increment the counter.
- FIX, results written into the output registers:
  - divz: `QUOT_o` = 0xFFFFFFFF, `REM_o` = original dividend, `DIVZ_o` = 1.
  - Otherwise: `QUOT_o` = sign_q ? −quot : quot, `REM_o` = sign_r ? −rem : rem, `DIVZ_o` = 0.
  - Quotient truncates toward zero. Remainder sign follows the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF produces `QUOT_o` = 0x80000000 and `REM_o` = 0, with no special case needed.
- `EN_i` while `BUSY_o`=1 is ignored; no queueing.
- `QUOT_o`, `REM_o` and `DIVZ_o` change only in FIX. They hold the previous result throughout a new operation.

## Timing
- Reset values: `BUSY_o`=0, `VALID_o`=0, `QUOT_o`=0, `REM_o`=0, `DIVZ_o`=0. FSM = IDLE, counter = 0.
- `EN_i` high at edge k:
  - `BUSY_o`=1 and `VALID_o`=0 from edge k.
  - Iterations occur on edges k+1..k+32.
  - FIX is edge k+33, which sets `BUSY_o`=0 and `VALID_o`=1 with results valid.
- Latency is fixed at 33 cycles for all operands, including divide-by-zero.
- `VALID_o` stays high until the next accepted `EN_i`.
- Back-to-back: `EN_i` held high continuously is accepted in the cycle after FIX, giving a 34-cycle throughput.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values and no `VALID_o` pulse is produced.

## Structure
- Package `divider_pkg`:
  - `DW`=32 and `CNT_W`=6.
  - State enum `div_state_t` {IDLE, CALC, FIX}.
  - Divide-by-zero quotient constant `DIVZ_QUOT`=32'hFFFF_FFFF.
- Sub-module `subtractor_33b`: a 33b ripple subtractor. It is built from the existing `adder_RCA_33b` with B inverted and carry-in = 1. Borrow = ~C_o.
- Negation in accept/FIX uses a shared 32b conditional negator (invert + increment), local to `divider_seq`.

## Test plan
- Unsigned 100 / 7, `EN_i` one cycle: `BUSY_o` for 33 cycles, then `VALID_o`=1, `QUOT_o`=14, `REM_o`=2, `DIVZ_o`=0.
- Signed −7 / 2 (0xFFFFFFF9 / 2): `QUOT_o`=0xFFFFFFFD, `REM_o`=0xFFFFFFFF. Signed 7 / −2: `QUOT_o`=0xFFFFFFFD, `REM_o`=1.
- 0x00001234 / 0, both modes: `QUOT_o`=0xFFFFFFFF, `REM_o`=0x00001234, `DIVZ_o`=1, same 33-cycle latency.
- 0x80000000 / 0xFFFFFFFF:
  - Signed: `QUOT_o`=0x80000000, `REM_o`=0.
  - Unsigned: `QUOT_o`=0, `REM_o`=0x80000000.
- `EN_i` pulsed at busy cycle 5 with different operands: ignored; the result matches the first operands and outputs stay unchanged until FIX.
- `RSTN_i` low at busy cycle 10: all outputs 0 immediately. A subsequent 0xFFFFFFFF / 0x10 unsigned gives `QUOT_o`=0x0FFFFFFF, `REM_o`=0xF.
